// File: rtl/key_ps2_tx_if.sv
// Request/line bundle for key_ps2_tx: key request handshake plus the generated PS/2 lines.
// The master drives key requests; the slave (key_ps2_tx) drives ready, status and PS/2 lines.
interface key_ps2_tx_if;
    logic [3:0] key_in;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       invalid;

    modport master (
        output key_in, key_release, key_valid,
        input  key_ready, ps2_clk, ps2_data, busy, invalid
    );

    modport slave (
        input  key_in, key_release, key_valid,
        output key_ready, ps2_clk, ps2_data, busy, invalid
    );
endinterface

// File: rtl/key_ps2_tx.sv
// PS/2 device-side transmitter: turns key make/break requests into set-2 scan-code frames.
// Optional macro BREAK_CODE_EN enables the 0xF0 break prefix; without it break requests are dropped.
module key_ps2_tx #(
    parameter int unsigned HALF_PERIOD = 4000,
    parameter int unsigned GAP_HALVES  = 2
) (
    input  logic         clk,
    input  logic         rst,
    key_ps2_tx_if.slave  bus
);

    localparam logic [15:0] HpLast    = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GapLast   = 16'(GAP_HALVES - 1);
    localparam logic [15:0] FrameLast = 16'd21;

    typedef enum logic [1:0] {StIdle, StFrame, StGap} state_e;

    state_e      state_q;
    logic [15:0] half_cnt_q;
    logic [15:0] half_idx_q;
    logic [10:0] frame_q;
    logic [7:0]  code_q;
    logic        second_q;
    logic        clk_q;
    logic        data_q;
    logic        invalid_q;

    function automatic logic [7:0] scan_code(input logic [3:0] k);
        case (k)
            4'd0:    return 8'h70;
            4'd1:    return 8'h69;
            4'd2:    return 8'h72;
            4'd3:    return 8'h7A;
            4'd4:    return 8'h6B;
            4'd5:    return 8'h73;
            4'd6:    return 8'h74;
            4'd7:    return 8'h6C;
            4'd8:    return 8'h75;
            4'd9:    return 8'h7D;
            4'd10:   return 8'h79;
            4'd11:   return 8'h7B;
            4'd12:   return 8'h7C;
            4'd13:   return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    // Bit 0 is the start bit; the frame shifts right as each bit begins.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            half_cnt_q <= '0;
            half_idx_q <= '0;
            frame_q    <= '0;
            code_q     <= '0;
            second_q   <= 1'b0;
            clk_q      <= 1'b1;
            data_q     <= 1'b1;
            invalid_q  <= 1'b0;
        end else begin
            invalid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.key_valid) begin
                        if (bus.key_in > 4'd13) begin
                            invalid_q <= 1'b1;
                        end else if (!bus.key_release) begin
                            state_q    <= StFrame;
                            frame_q    <= make_frame(scan_code(bus.key_in));
                            code_q     <= scan_code(bus.key_in);
                            second_q   <= 1'b0;
                            half_cnt_q <= '0;
                            half_idx_q <= '0;
                            clk_q      <= 1'b1;
                            data_q     <= 1'b0;
                        end
`ifdef BREAK_CODE_EN
                        else begin
                            state_q    <= StFrame;
                            frame_q    <= make_frame(8'hF0);
                            code_q     <= scan_code(bus.key_in);
                            second_q   <= 1'b1;
                            half_cnt_q <= '0;
                            half_idx_q <= '0;
                            clk_q      <= 1'b1;
                            data_q     <= 1'b0;
                        end
`endif
                    end
                end
                StFrame: begin
                    if (half_cnt_q == HpLast) begin
                        half_cnt_q <= '0;
                        if (half_idx_q == FrameLast) begin
                            half_idx_q <= '0;
                            clk_q      <= 1'b1;
                            data_q     <= 1'b1;
                            if (second_q) begin
                                state_q  <= StGap;
                                second_q <= 1'b0;
                                frame_q  <= make_frame(code_q);
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            half_idx_q <= half_idx_q + 16'd1;
                            // Odd half ending means a new bit starts next cycle.
                            if (half_idx_q[0]) begin
                                clk_q   <= 1'b1;
                                data_q  <= frame_q[1];
                                frame_q <= {1'b0, frame_q[10:1]};
                            end else begin
                                clk_q <= 1'b0;
                            end
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q + 16'd1;
                    end
                end
                StGap: begin
                    if (half_cnt_q == HpLast) begin
                        half_cnt_q <= '0;
                        if (half_idx_q == GapLast) begin
                            state_q    <= StFrame;
                            half_idx_q <= '0;
                            clk_q      <= 1'b1;
                            data_q     <= frame_q[0];
                        end else begin
                            half_idx_q <= half_idx_q + 16'd1;
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.key_ready = (state_q == StIdle) && !rst;
    assign bus.busy      = (state_q != StIdle);
    assign bus.ps2_clk   = clk_q;
    assign bus.ps2_data  = data_q;
    assign bus.invalid   = invalid_q;

endmodule

// File: tb/tb_key_ps2_tx.sv
// Self-checking bench for key_ps2_tx: per-cycle waveform comparison against a frame-level model.
// Honours BREAK_CODE_EN the same way as the design when choosing break expectations.
module tb_key_ps2_tx;

    localparam int unsigned HP = 2;
    localparam int unsigned GH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_ps2_tx_if bus ();

    key_ps2_tx #(
        .HALF_PERIOD(HP),
        .GAP_HALVES (GH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [1:0] exp_q[$];   // expected {ps2_clk, ps2_data} per cycle
    logic [7:0] scan_tbl [0:13] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74,
                                    8'h6C, 8'h75, 8'h7D, 8'h79, 8'h7B, 8'h7C, 8'h5A};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] b);
        logic [10:0] bits;
        logic        par;
        par  = ($countones(b) % 2 == 0);
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < int'(HP); c++) exp_q.push_back({1'b1, bits[i]});
            for (int c = 0; c < int'(HP); c++) exp_q.push_back({1'b0, bits[i]});
        end
    endtask

    task automatic push_gap();
        for (int c = 0; c < int'(GH * HP); c++) exp_q.push_back(2'b11);
    endtask

    task automatic build_expected(input int k, input logic r);
        exp_q.delete();
        if (k > 13) return;
`ifdef BREAK_CODE_EN
        if (r) begin
            push_frame(8'hF0);
            push_gap();
        end
        push_frame(scan_tbl[k]);
`else
        if (!r) push_frame(scan_tbl[k]);
`endif
    endtask

    // Called at #1 after an edge; returns at the first cycle after the accept.
    task automatic send(input logic [3:0] k, input logic r, input string name);
        tests++;
        if (bus.key_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before_send: got %b want 1", name, bus.key_ready);
        end
        bus.key_in      = k;
        bus.key_release = r;
        bus.key_valid   = 1'b1;
        tick();
        bus.key_valid   = 1'b0;
    endtask

    task automatic check_wave(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if ({bus.ps2_clk, bus.ps2_data} !== exp_q[i] || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL %s cycle %0d: got clk/data=%b busy=%b want %b busy=1",
                         name, i, {bus.ps2_clk, bus.ps2_data}, bus.busy, exp_q[i]);
            end
            tick();
        end
        tests++;
        if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || {bus.ps2_clk, bus.ps2_data} !== 2'b11)
        begin
            fails++;
            $display("FAIL %s end: got ready=%b busy=%b lines=%b want 1 0 11", name,
                     bus.key_ready, bus.busy, {bus.ps2_clk, bus.ps2_data});
        end
    endtask

    task automatic check_quiet(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            tests++;
            if ({bus.ps2_clk, bus.ps2_data} !== 2'b11 || bus.key_ready !== 1'b1 ||
                bus.invalid !== 1'b0) begin
                fails++;
                $display("FAIL %s cycle %0d: got lines=%b ready=%b invalid=%b want 11 1 0",
                         name, i, {bus.ps2_clk, bus.ps2_data}, bus.key_ready, bus.invalid);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({bus.ps2_clk, bus.ps2_data, bus.busy, bus.invalid, bus.key_ready} !== 5'b11000) begin
            fails++;
            $display("FAIL reset_state: got clk,data,busy,inv,ready=%b want 11000",
                     {bus.ps2_clk, bus.ps2_data, bus.busy, bus.invalid, bus.key_ready});
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.key_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", bus.key_ready);
        end
        tick();
    endtask

    task automatic test_make();
        build_expected(5, 1'b0);
        tests++;
        if (exp_q.size() != 44) begin
            fails++;
            $display("FAIL make_len: got %0d want 44", exp_q.size());
        end
        send(4'd5, 1'b0, "make5");
        check_wave("make5");
    endtask

    task automatic test_break();
        build_expected(13, 1'b1);
        send(4'd13, 1'b1, "break13");
`ifdef BREAK_CODE_EN
        check_wave("break13");
`else
        check_quiet(60, "break13_dropped");
`endif
    endtask

    task automatic test_invalid();
        for (int j = 0; j < 2; j++) begin
            send(4'(14 + j), 1'(j), "invalid");
            tests++;
            if (bus.invalid !== 1'b1 || bus.busy !== 1'b0 ||
                {bus.ps2_clk, bus.ps2_data} !== 2'b11) begin
                fails++;
                $display("FAIL invalid_pulse key %0d: got inv=%b busy=%b lines=%b want 1 0 11",
                         14 + j, bus.invalid, bus.busy, {bus.ps2_clk, bus.ps2_data});
            end
            tick();
            check_quiet(4, "invalid_after");
        end
    endtask

    task automatic test_reset_midframe();
        send(4'd5, 1'b0, "midreset");
        repeat (10) tick();
        rst = 1'b1;
        tick();
        tests++;
        if ({bus.ps2_clk, bus.ps2_data} !== 2'b11 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midframe_reset: got lines=%b busy=%b want 11 0",
                     {bus.ps2_clk, bus.ps2_data}, bus.busy);
        end
        rst = 1'b0;
        #1;
        check_quiet(5, "after_reset_idle");
        build_expected(0, 1'b0);
        send(4'd0, 1'b0, "after_reset_key0");
        check_wave("after_reset_key0");
    endtask

    task automatic test_back_to_back();
        int k1;
        int k2;
        k1 = $urandom_range(13, 0);
        k2 = $urandom_range(13, 0);
        build_expected(k1, 1'b0);
        send(4'(k1), 1'b0, "b2b_first");
        bus.key_valid = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if ({bus.ps2_clk, bus.ps2_data} !== exp_q[i] || bus.key_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_first cycle %0d: got %b ready=%b want %b ready=0",
                         i, {bus.ps2_clk, bus.ps2_data}, bus.key_ready, exp_q[i]);
            end
            bus.key_in      = 4'($urandom);
            bus.key_release = 1'($urandom);
            tick();
        end
        bus.key_in      = 4'(k2);
        bus.key_release = 1'b0;
        #1;
        tests++;
        if (bus.key_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready_rise: got %b want 1", bus.key_ready);
        end
        tick();
        bus.key_valid = 1'b0;
        build_expected(k2, 1'b0);
        check_wave("b2b_second");
    endtask

    task automatic test_random();
        int   k;
        logic r;
        for (int n = 0; n < 8; n++) begin
            k = $urandom_range(13, 0);
            r = 1'($urandom);
            build_expected(k, r);
            send(4'(k), r, "random");
            if (exp_q.size() == 0) check_quiet(8, "random_dropped");
            else check_wave("random");
            tick();
        end
    endtask

    initial begin
        bus.key_in      = '0;
        bus.key_release = 1'b0;
        bus.key_valid   = 1'b0;
        test_reset();
        test_make();
        test_break();
        test_invalid();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
